ft245_tx_packetizer: RTL
========================

Name: ft245_tx_packetizer

Overview:
- Frames a 32-bit sample stream into fixed-size packets and writes them into the master TX FIFO.
- The FT245 controller drains that FIFO in bursts of PACKET_WORDS, so every packet is exactly one USB burst.
- Each packet is a header word, (PACKET_WORDS-2) payload words, then a trailer word.
- Short packets are zero-padded on flush, on idle timeout, or when enable drops.

Parameters:
- PACKET_WORDS, 1024, total words per packet including header and trailer; must equal the controller burst size; minimum 4.
- SYNC_HDR, 8'hA5, header sync byte.
- SYNC_TRL, 8'h5A, trailer sync byte.
- TIMEOUT, 4096, idle cycles in PAYLOAD before auto-padding; 0 disables the timeout.
- TMO_W, 16, timeout counter width.

Ports:
- usb_clk  in  1  FT245 60 MHz clock; only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  level; packetizing allowed.
- flush  in  1  single-cycle pulse; close the current packet early.
- s_data  in  32  sample word.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- tx_fifo_full  in  1  TX FIFO full; no write may occur while high.
- tx_fifo_data  out  32  word to the TX FIFO.
- tx_fifo_write  out  1  write strobe; one word per high cycle.
- seq  out  8  sequence number of the next packet.
- pkt_done  out  1  one-cycle pulse after a trailer is written.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async): state=IDLE; seq=0; slot counter, timeout counter and flush_pending cleared; s_ready=0, tx_fifo_write=0, pkt_done=0, busy=0, tx_fifo_data=0.
- Write condition: tx_fifo_write is combinational = emit && !tx_fifo_full, where emit is high in HEADER, PAD, TRAILER, and in PAYLOAD when s_valid && s_ready.
- tx_fifo_data mux:
  - HEADER: {SYNC_HDR, seq, 16'h0000}
  - PAYLOAD: s_data (zero-latency pass-through)
  - PAD: 32'h0
  - TRAILER: {SYNC_TRL, seq, valid_count[15:0]}, where valid_count = real payload words in this packet
- s_ready = (state==PAYLOAD) && !tx_fifo_full && !flush_pending && !timeout_hit.
- flush_pending:
  - Set by flush while state is HEADER or PAYLOAD.
  - Also set when enable is low in those states.
  - Cleared on entry to TRAILER.
  - A flush seen in IDLE is discarded; empty packets are never produced.
- FSM:
  - IDLE -> HEADER when enable && s_valid.
  - HEADER -> PAYLOAD when the header word is written.
  - PAYLOAD -> TRAILER when the accepted word fills the last slot (slot == PACKET_WORDS-3 at accept).
  - PAYLOAD -> PAD when (flush_pending || timeout_hit) and slots remain. If zero payload words were accepted, pad the full payload anyway.
  - PAD -> TRAILER when the last slot is written.
  - TRAILER -> IDLE when the trailer is written. On that edge: seq <= seq+1 (wraps 255->0) and pkt_done pulses next cycle.
- Slot counter: width $clog2(PACKET_WORDS), reset on HEADER entry. Increments on every payload or pad write. valid_count counts payload writes only.
- Timeout counter:
  - Increments each PAYLOAD cycle with no accept; resets on accept and on leaving PAYLOAD.
  - timeout_hit when count == TIMEOUT-1 and TIMEOUT != 0.
  - Saturates and never wraps.
- Simultaneous events:
  - A flush in the same cycle as the final-slot accept goes to TRAILER, not PAD.
  - tx_fifo_full stalls any state with no state change and no counter change.
- Every packet is exactly PACKET_WORDS writes, with no gaps other than full or s_valid stalls.
- Reset mid-packet aborts with no completion. The FIFO must be reset with the same reset so no partial packet survives.

Decomposition:
- Shared package ft245_pkg holds:
  - state encoding (one-hot localparams IDLE/HEADER/PAYLOAD/PAD/TRAILER)
  - SYNC_HDR/SYNC_TRL defaults
  - PACKET_WORDS=1024, shared with ft245_controller
- One sub-module: pkt_timeout_ctr (parametric saturating idle counter with clear/inc/hit).
- The FSM and datapath stay in the top module.

Test Plan (PACKET_WORDS=8, TIMEOUT=16):
- Full packet: stream 6 words 0x1..0x6, full=0 -> writes A5000000, 1..6, 5A000006; pkt_done once; seq=1.
- Flush: 2 words 0xAA,0xBB then flush -> A5xx0000, AA, BB, 0,0,0,0, 5Axx0002; 8 writes total.
- Timeout: 1 word then s_valid=0 for 20 cycles -> PAD begins 16 cycles after the accept; trailer count field = 0001.
- Backpressure: tx_fifo_full high for 5 cycles mid-payload -> no write, s_ready=0 and no counter change during stall; packet contents identical to the unstalled case.
- Wrap and idle flush: 256 packets -> seq wraps to 0 on the 257th header; flush pulse in IDLE -> no writes.
- Async reset: assert rst_n low mid-PAD -> outputs 0 immediately, seq=0; next packet starts at A5000000.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 TX path: packet geometry, sync bytes and
// the packetizer state encoding.
package ft245_pkg;

  localparam int unsigned DEFAULT_PACKET_WORDS = 1024;
  localparam logic [7:0]  DEFAULT_SYNC_HDR     = 8'hA5;
  localparam logic [7:0]  DEFAULT_SYNC_TRL     = 8'h5A;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_HEADER  = 5'b00010,
    ST_PAYLOAD = 5'b00100,
    ST_PAD     = 5'b01000,
    ST_TRAILER = 5'b10000
  } state_e;

endpackage

// File: rtl/ft245_tx_packetizer_if.sv
// Sample-stream and TX-FIFO write bus of the packetizer.
interface ft245_tx_packetizer_if;

  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx_fifo_full;
  logic [31:0] tx_fifo_data;
  logic        tx_fifo_write;

  modport slave (
    input  s_data, s_valid, tx_fifo_full,
    output s_ready, tx_fifo_data, tx_fifo_write
  );

  modport master (
    output s_data, s_valid, tx_fifo_full,
    input  s_ready, tx_fifo_data, tx_fifo_write
  );

endinterface

// File: rtl/ft245_tx_packetizer_pkt_timeout_ctr.sv
// Saturating idle counter; hit flags TIMEOUT-1 idle cycles, TIMEOUT=0 disables.
module pkt_timeout_ctr #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TMO_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (TIMEOUT != 0) && (cnt_q == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ft245_tx_packetizer.sv
// Frames a 32-bit sample stream into fixed PACKET_WORDS packets
// (header, payload/pad, trailer) written into the FT245 TX FIFO.
module ft245_tx_packetizer
  import ft245_pkg::*;
#(
  parameter int unsigned PACKET_WORDS = DEFAULT_PACKET_WORDS,
  parameter logic [7:0]  SYNC_HDR     = DEFAULT_SYNC_HDR,
  parameter logic [7:0]  SYNC_TRL     = DEFAULT_SYNC_TRL,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned TMO_W        = 16
) (
  input  logic                        usb_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flush,
  ft245_tx_packetizer_if.slave        bus,
  output logic [7:0]                  seq,
  output logic                        pkt_done,
  output logic                        busy
);

  localparam int unsigned       SLOT_W    = $clog2(PACKET_WORDS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACKET_WORDS - 3);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] vcnt_q, vcnt_d;
  logic [7:0]        seq_q, seq_d;
  logic              flush_pend_q, flush_pend_d;
  logic              pkt_done_q, pkt_done_d;

  logic        full, accept, emit, tmo_hit, tmo_clr, tmo_inc, s_ready;
  logic [31:0] data;
  logic [15:0] vcnt16;

  assign full    = bus.tx_fifo_full;
  assign s_ready = (state_q == ST_PAYLOAD) && !full && !flush_pend_q && !tmo_hit;
  assign accept  = s_ready && bus.s_valid;
  assign vcnt16  = 16'(vcnt_q);

  assign tmo_clr = (state_q != ST_PAYLOAD) || accept;
  assign tmo_inc = (state_q == ST_PAYLOAD) && !full;

  pkt_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk   (usb_clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .inc   (tmo_inc),
    .hit   (tmo_hit)
  );

  always_comb begin
    emit = 1'b0;
    data = '0;
    unique case (state_q)
      ST_HEADER: begin
        emit = 1'b1;
        data = {SYNC_HDR, seq_q, 16'h0000};
      end
      ST_PAYLOAD: begin
        emit = accept;
        data = bus.s_data;
      end
      ST_PAD: begin
        emit = 1'b1;
      end
      ST_TRAILER: begin
        emit = 1'b1;
        data = {SYNC_TRL, seq_q, vcnt16};
      end
      default: begin
        emit = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    vcnt_d       = vcnt_q;
    seq_d        = seq_q;
    flush_pend_d = flush_pend_q;
    pkt_done_d   = 1'b0;

    if (((state_q == ST_HEADER) || (state_q == ST_PAYLOAD)) && (flush || !enable)) begin
      flush_pend_d = 1'b1;
    end

    // A full FIFO freezes every state and counter; only flush capture proceeds.
    if (!full) begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable && bus.s_valid) begin
            state_d = ST_HEADER;
            slot_d  = '0;
            vcnt_d  = '0;
          end
        end
        ST_HEADER: begin
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (accept) begin
            slot_d = slot_q + SLOT_W'(1);
            vcnt_d = vcnt_q + SLOT_W'(1);
            if (slot_q == LAST_SLOT) begin
              state_d = ST_TRAILER;
            end
          end else if (flush_pend_q || tmo_hit) begin
            state_d = ST_PAD;
          end
        end
        ST_PAD: begin
          slot_d = slot_q + SLOT_W'(1);
          if (slot_q == LAST_SLOT) begin
            state_d = ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          state_d    = ST_IDLE;
          seq_d      = seq_q + 8'd1;
          pkt_done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Leaving PAYLOAD on the final accept wins over a coincident flush.
    if ((state_d == ST_TRAILER) && (state_q != ST_TRAILER)) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      vcnt_q       <= '0;
      seq_q        <= '0;
      flush_pend_q <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      vcnt_q       <= vcnt_d;
      seq_q        <= seq_d;
      flush_pend_q <= flush_pend_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.tx_fifo_write = emit && !full;
  assign bus.tx_fifo_data  = data;
  assign seq               = seq_q;
  assign pkt_done          = pkt_done_q;
  assign busy              = (state_q != ST_IDLE);

endmodule
